mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, data memory) onto one single-port memory.
// One transaction in flight; data wins ties, but fetch gets the slot after two back-to-back data grants.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_ack,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]          state;
    logic [1:0]          dm_streak;
    logic                owner_dm;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W/8-1:0] lat_be;
    logic                grant_if;
    logic                grant_dm;

    // No arbitration in the ack cycle: the requester is still updating its request.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state == IDLE && !(if_ack || dm_ack)) begin
            if (if_req && (!dm_req || dm_streak == 2'd2))
                grant_if = 1'b1;
            else if (dm_req)
                grant_dm = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dm_streak <= 2'd0;
            owner_dm  <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        owner_dm  <= 1'b1;
                        lat_we    <= dm_we;
                        lat_addr  <= dm_addr;
                        lat_wdata <= dm_wdata;
                        lat_be    <= dm_be;
                        // Streak only counts while fetch is actually being held off.
                        dm_streak <= if_req ? dm_streak + 2'd1 : 2'd0;
                        state     <= ISSUE;
                    end else if (grant_if) begin
                        owner_dm  <= 1'b0;
                        lat_we    <= 1'b0;
                        lat_addr  <= if_addr;
                        lat_wdata <= '0;
                        lat_be    <= '0;
                        dm_streak <= 2'd0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready)
                        state <= WAIT;
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (owner_dm) begin
                            dm_ack   <= 1'b1;
                            dm_rdata <= mem_rdata;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_valid = (state == ISSUE);
    assign mem_we    = lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_be    = lat_be;
    assign stall     = (if_req & ~if_ack) | (dm_req & ~dm_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: byte-level memory model, randomized requesters and responder,
// directed scenarios for priority, fairness, backpressure, field latching and reset abandonment.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] DM_BASE = 32'h0000_0100;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [3:0]  dm_be = '0;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall(stall)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    req_t        exp_if_req[$];
    req_t        exp_dm_req[$];
    logic [31:0] exp_if_rsp[$];
    logic [32:0] exp_dm_rsp[$];
    logic [31:0] grant_log[$];
    logic [7:0]  mem_b [int unsigned];
    logic [7:0]  ref_b [int unsigned];

    int          pend_cnt = 0;
    logic [31:0] pend_data = '0;
    int          hold_low = 0;
    int          force_lat = 0;
    int          low_cycles = 0;
    int          n0;
    int          bnd;
    int          if_gap;
    int          dm_gap;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        logic [31:0] w;
        w = ((a & ~32'h3) * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
        w = w >> {a[1:0], 3'b000};
        return w[7:0];
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] d;
        for (int k = 0; k < 4; k++)
            d[8*k +: 8] = ref_b.exists(a + 32'(k)) ? ref_b[a + 32'(k)] : init_byte(a + 32'(k));
        return d;
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int k = 0; k < 4; k++)
            if (be[k]) ref_b[a + 32'(k)] = d[8*k +: 8];
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        logic [31:0] d;
        for (int k = 0; k < 4; k++)
            d[8*k +: 8] = mem_b.exists(a + 32'(k)) ? mem_b[a + 32'(k)] : init_byte(a + 32'(k));
        return d;
    endfunction

    function automatic void mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int k = 0; k < 4; k++)
            if (be[k]) mem_b[a + 32'(k)] = d[8*k +: 8];
    endfunction

    task automatic wait_ack(input bit is_dm);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(is_dm ? dm_ack : if_ack) && n < 300);
        check(is_dm ? "dm_ack_timeout" : "if_ack_timeout", 32'(n >= 300), 32'd0);
    endtask

    task automatic if_op(input logic [31:0] a);
        req_t r;
        if_addr = a;
        if_req  = 1'b1;
        r = {1'b0, a, 32'h0, 4'h0};
        exp_if_req.push_back(r);
        exp_if_rsp.push_back(ref_read(a));
        wait_ack(1'b0);
    endtask

    task automatic dm_op(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        req_t r;
        dm_we = we; dm_addr = a; dm_wdata = wd; dm_be = be;
        dm_req = 1'b1;
        r = {we, a, wd, be};
        exp_dm_req.push_back(r);
        if (we) begin
            ref_write(a, wd, be);
            exp_dm_rsp.push_back({1'b0, 32'h0});
        end else begin
            exp_dm_rsp.push_back({1'b1, ref_read(a)});
        end
        wait_ack(1'b1);
    endtask

    // Memory responder: random backpressure and latency, byte-enable writes, one response per acceptance.
    task automatic accept();
        req_t e;
        check("one_outstanding", 32'(pend_cnt), 32'd0);
        grant_log.push_back(mem_addr);
        if (mem_addr < DM_BASE) begin
            if (exp_if_req.size() == 0) begin
                check("if_grant_expected", 32'd0, 32'd1);
            end else begin
                e = exp_if_req.pop_front();
                check("if_mem_addr", mem_addr, e.addr);
                check("if_mem_we", 32'(mem_we), 32'd0);
                check("if_mem_be", 32'(mem_be), 32'd0);
            end
            pend_data = mem_read(mem_addr);
        end else begin
            if (exp_dm_req.size() == 0) begin
                check("dm_grant_expected", 32'd0, 32'd1);
            end else begin
                e = exp_dm_req.pop_front();
                check("dm_mem_addr", mem_addr, e.addr);
                check("dm_mem_we", 32'(mem_we), 32'(e.we));
                if (e.we) begin
                    check("dm_mem_wdata", mem_wdata, e.wdata);
                    check("dm_mem_be", 32'(mem_be), 32'(e.be));
                end
            end
            if (mem_we) begin
                mem_write(mem_addr, mem_wdata, mem_be);
                pend_data = $urandom;
            end else begin
                pend_data = mem_read(mem_addr);
            end
        end
        pend_cnt = (force_lat != 0) ? force_lat : int'($urandom_range(1, 3));
    endtask

    initial begin
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_data;
                end
            end
            if (hold_low > 0) begin
                mem_ready = 1'b0;
                hold_low--;
            end else begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            if (mem_valid && mem_ready) accept();
        end
    end

    // Output monitor: scoreboard pops on acks, stall equation, held request under backpressure.
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_we = 1'b0;
    logic        prev_if_ack = 1'b0, prev_dm_ack = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    logic [3:0]  prev_be = '0;
    logic [31:0] mon_if_e;
    logic [32:0] mon_dm_e;

    initial begin
        forever begin
            @(negedge clk);
            check("stall", 32'(stall), 32'((if_req & ~if_ack) | (dm_req & ~dm_ack)));
            if (!rst && mem_valid && !mem_ready) low_cycles++;
            if (!rst && prev_valid && !prev_ready) begin
                check("issue_valid_held", 32'(mem_valid), 32'd1);
                check("issue_addr_held", mem_addr, prev_addr);
                check("issue_wdata_held", mem_wdata, prev_wdata);
                check("issue_we_be_held", {27'd0, mem_we, mem_be}, {27'd0, prev_we, prev_be});
            end
            if (if_ack) begin
                check("if_ack_single_pulse", 32'(prev_if_ack), 32'd0);
                if (exp_if_rsp.size() == 0) begin
                    check("if_ack_expected", 32'd0, 32'd1);
                end else begin
                    mon_if_e = exp_if_rsp.pop_front();
                    check("if_rdata", if_rdata, mon_if_e);
                end
            end
            if (dm_ack) begin
                check("dm_ack_single_pulse", 32'(prev_dm_ack), 32'd0);
                if (exp_dm_rsp.size() == 0) begin
                    check("dm_ack_expected", 32'd0, 32'd1);
                end else begin
                    mon_dm_e = exp_dm_rsp.pop_front();
                    if (mon_dm_e[32]) check("dm_rdata", dm_rdata, mon_dm_e[31:0]);
                end
            end
            prev_valid = mem_valid; prev_ready = mem_ready; prev_we = mem_we;
            prev_addr = mem_addr; prev_wdata = mem_wdata; prev_be = mem_be;
            prev_if_ack = if_ack; prev_dm_ack = dm_ack;
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete, fails=%0d", fails);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_if_ack", 32'(if_ack), 32'd0);
        check("rst_dm_ack", 32'(dm_ack), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_we_be", {27'd0, mem_we, mem_be}, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        rst = 1'b0;

        // Single fetch with known instruction word.
        ref_write(32'h4, 32'h0050_0093, 4'hF);
        mem_write(32'h4, 32'h0050_0093, 4'hF);
        @(posedge clk); #1;
        n0 = grant_log.size();
        if_op(32'h0000_0004);
        if_req = 1'b0;
        check("req034_if_rdata", if_rdata, 32'h0050_0093);
        check("req034_grant_addr", (grant_log.size() > n0) ? grant_log[n0] : 32'hFFFF_FFFF, 32'h4);

        // Simultaneous requests: data store first, then fetch.
        repeat (2) @(posedge clk); #1;
        n0 = grant_log.size();
        fork
            begin if_op(32'h0000_0040); if_req = 1'b0; end
            begin dm_op(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF); dm_req = 1'b0; end
        join
        check("req035_first", (grant_log.size() > n0) ? grant_log[n0] : 32'hFFFF_FFFF, 32'h100);
        check("req035_second", (grant_log.size() > n0 + 1) ? grant_log[n0+1] : 32'hFFFF_FFFF, 32'h40);

        // Three back-to-back loads with a fetch waiting: dm, dm, if, dm.
        repeat (2) @(posedge clk); #1;
        n0 = grant_log.size();
        fork
            begin if_op(32'h0000_0020); if_req = 1'b0; end
            begin
                dm_op(1'b0, DM_BASE + 32'h4, 32'h0, 4'hF);
                dm_op(1'b0, DM_BASE + 32'h8, 32'h0, 4'hF);
                dm_op(1'b0, DM_BASE + 32'hC, 32'h0, 4'hF);
                dm_req = 1'b0;
            end
        join
        for (int k = 0; k < 4; k++)
            check($sformatf("req036_order_%0d_is_dm", k),
                  (grant_log.size() > n0 + k) ? 32'(grant_log[n0+k] >= DM_BASE) : 32'hFFFF_FFFF,
                  (k == 2) ? 32'd0 : 32'd1);

        // Backpressure: ready low while the request sits in ISSUE.
        repeat (2) @(posedge clk); #1;
        low_cycles = 0;
        hold_low = 8;
        if_op(32'h0000_0030);
        if_req = 1'b0;
        check("req037_ready_low_cycles_ge5", 32'(low_cycles >= 5), 32'd1);

        // Request inputs change while waiting for the response.
        repeat (2) @(posedge clk); #1;
        n0 = grant_log.size();
        force_lat = 3;
        fork
            begin dm_op(1'b0, DM_BASE + 32'h10, 32'h0, 4'hF); dm_req = 1'b0; end
            begin
                bnd = 0;
                while (grant_log.size() == n0 && bnd < 200) begin @(negedge clk); bnd++; end
                @(posedge clk); #2;
                dm_addr = DM_BASE + 32'h40;
                dm_wdata = 32'h1234_5678;
                @(negedge clk);
                check("req039_mem_addr_held", mem_addr, DM_BASE + 32'h10);
            end
        join
        force_lat = 0;

        // Reset while waiting for a response; the late response must be dropped.
        repeat (2) @(posedge clk); #1;
        force_lat = 4;
        n0 = grant_log.size();
        begin
            req_t r;
            dm_we = 1'b0; dm_addr = DM_BASE + 32'h8; dm_be = 4'hF; dm_req = 1'b1;
            r = {1'b0, DM_BASE + 32'h8, dm_wdata, 4'hF};
            exp_dm_req.push_back(r);
        end
        bnd = 0;
        while (grant_log.size() == n0 && bnd < 200) begin @(negedge clk); bnd++; end
        check("req038_granted", 32'(bnd < 200), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        dm_req = 1'b0;
        #1;
        check("req038_mem_valid", 32'(mem_valid), 32'd0);
        check("req038_acks", {30'd0, if_ack, dm_ack}, 32'd0);
        check("req038_if_rdata", if_rdata, 32'd0);
        check("req038_dm_rdata", dm_rdata, 32'd0);
        check("req038_mem_addr", mem_addr, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("req038_no_dm_ack", 32'(dm_ack), 32'd0);
            check("req038_stays_idle", 32'(mem_valid), 32'd0);
        end
        force_lat = 0;

        // Randomized concurrent traffic.
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    if_gap = int'($urandom_range(0, 3));
                    if (if_gap != 0) begin
                        if_req = 1'b0;
                        repeat (if_gap) @(posedge clk);
                        #1;
                    end
                    if_op(32'(4 * $urandom_range(0, 63)));
                end
                if_req = 1'b0;
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    dm_gap = int'($urandom_range(0, 3));
                    if (dm_gap != 0) begin
                        dm_req = 1'b0;
                        repeat (dm_gap) @(posedge clk);
                        #1;
                    end
                    dm_op(1'($urandom_range(0, 1)), DM_BASE + 32'(4 * $urandom_range(0, 15)),
                          $urandom, 4'($urandom_range(1, 15)));
                end
                dm_req = 1'b0;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        check("if_rsp_drained", 32'(exp_if_rsp.size()), 32'd0);
        check("dm_rsp_drained", 32'(exp_dm_rsp.size()), 32'd0);
        check("dm_req_drained", 32'(exp_dm_req.size()), 32'd0);
        check("if_req_drained", 32'(exp_if_req.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
